// File: rtl/slave_in.sv
// Serial-in slave: shifts in an address/burst header, then write beats or a read request.
// Optional even-parity bit per write beat when SLAVE_IN_PARITY_EN is defined.
module slave_in #(
  parameter int ADDR_LEN  = 12,
  parameter int DATA_LEN  = 8,
  parameter int BURST_LEN = 12
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 slave_enable,
  input  logic                 master_valid,
  input  logic                 write_en,
  input  logic                 read_en,
  input  logic                 rx_address,
  input  logic                 rx_burst,
  input  logic                 rx_data,
  output logic                 slave_ready,
  output logic [ADDR_LEN-1:0]  mem_addr,
  output logic [DATA_LEN-1:0]  mem_wdata,
  output logic                 mem_we,
  output logic                 read_req,
  output logic [ADDR_LEN-1:0]  read_addr,
  output logic [BURST_LEN-1:0] read_burst,
  output logic                 rx_done,
  output logic                 parity_err
);

  // state  | meaning
  // IDLE   | waiting for a frame start, slave_ready high
  // HEADER | shifting in address (and burst during its first BURST_LEN bits)
  // DATA   | shifting in write beats, one mem_we per completed beat
  // DONE   | write: rx_done cycle; read: read_req cycle followed by rx_done cycle
  typedef enum logic [1:0] {IDLE, HEADER, DATA, DONE} state_t;

`ifdef SLAVE_IN_PARITY_EN
  localparam int BEAT_BITS = DATA_LEN + 1;
`else
  localparam int BEAT_BITS = DATA_LEN;
`endif
  localparam int HCW = $clog2(ADDR_LEN);
  localparam int DCW = $clog2(BEAT_BITS);
  localparam logic [HCW-1:0] HDR_LOAD  = HCW'(ADDR_LEN - 2);
  localparam logic [DCW-1:0] BEAT_LOAD = DCW'(BEAT_BITS - 1);

  state_t               state;
  logic                 is_write;
  logic [HCW-1:0]       hdr_cnt;
  logic [DCW-1:0]       data_cnt;
  logic [BURST_LEN-1:0] beats_left;
  logic [ADDR_LEN-1:0]  addr_sr;
  logic [ADDR_LEN-1:0]  burst_sr;
  logic [ADDR_LEN-1:0]  cur_addr;
  logic [DATA_LEN-1:0]  data_sr;

  logic [ADDR_LEN-1:0]  addr_nxt;
  logic [ADDR_LEN-1:0]  burst_sr_nxt;
  logic [BURST_LEN-1:0] burst_eff;
  logic [DATA_LEN-1:0]  data_shift;
  logic [DATA_LEN-1:0]  beat_word;
  logic                 beat_ok;

  // Burst lane is shifted on every header bit; after ADDR_LEN shifts its
  // low BURST_LEN bits hold exactly the first BURST_LEN sampled bits.
  always_comb begin
    addr_nxt     = {rx_address, addr_sr[ADDR_LEN-1:1]};
    burst_sr_nxt = {rx_burst, burst_sr[ADDR_LEN-1:1]};
    burst_eff    = (burst_sr_nxt[BURST_LEN-1:0] == '0) ? BURST_LEN'(1)
                                                      : burst_sr_nxt[BURST_LEN-1:0];
    data_shift   = {rx_data, data_sr[DATA_LEN-1:1]};
`ifdef SLAVE_IN_PARITY_EN
    beat_word    = data_sr;
    beat_ok      = ~((^data_sr) ^ rx_data);
`else
    beat_word    = data_shift;
    beat_ok      = 1'b1;
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      slave_ready <= 1'b1;
      is_write    <= 1'b0;
      hdr_cnt     <= '0;
      data_cnt    <= '0;
      beats_left  <= '0;
      addr_sr     <= '0;
      burst_sr    <= '0;
      cur_addr    <= '0;
      data_sr     <= '0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      mem_we      <= 1'b0;
      read_req    <= 1'b0;
      read_addr   <= '0;
      read_burst  <= '0;
      rx_done     <= 1'b0;
`ifdef SLAVE_IN_PARITY_EN
      parity_err  <= 1'b0;
`endif
    end else begin
      mem_we   <= 1'b0;
      read_req <= 1'b0;
      rx_done  <= 1'b0;
      case (state)
        IDLE: begin
          if (slave_enable && master_valid && (write_en || read_en)) begin
            state       <= HEADER;
            slave_ready <= 1'b0;
            is_write    <= write_en;
            addr_sr     <= addr_nxt;
            burst_sr    <= burst_sr_nxt;
            hdr_cnt     <= HDR_LOAD;
          end
        end
        HEADER: begin
          if (!slave_enable) begin
            state       <= IDLE;
            slave_ready <= 1'b1;
          end else if (master_valid) begin
            addr_sr  <= addr_nxt;
            burst_sr <= burst_sr_nxt;
            if (hdr_cnt != '0) begin
              hdr_cnt <= hdr_cnt - HCW'(1);
            end else if (is_write) begin
              state      <= DATA;
              cur_addr   <= addr_nxt;
              beats_left <= burst_eff;
              data_cnt   <= BEAT_LOAD;
            end else begin
              state      <= DONE;
              read_req   <= 1'b1;
              read_addr  <= addr_nxt;
              read_burst <= burst_eff;
            end
          end
        end
        DATA: begin
          if (!slave_enable) begin
            state       <= IDLE;
            slave_ready <= 1'b1;
          end else if (master_valid) begin
            if (data_cnt != '0) begin
              data_sr  <= data_shift;
              data_cnt <= data_cnt - DCW'(1);
            end else begin
              // Address advances even when a bad-parity beat is dropped.
              data_cnt <= BEAT_LOAD;
              cur_addr <= cur_addr + ADDR_LEN'(1);
              if (beat_ok) begin
                mem_we    <= 1'b1;
                mem_addr  <= cur_addr;
                mem_wdata <= beat_word;
              end
`ifdef SLAVE_IN_PARITY_EN
              if (!beat_ok) parity_err <= 1'b1;
`endif
              if (beats_left == BURST_LEN'(1)) begin
                state   <= DONE;
                rx_done <= 1'b1;
              end else begin
                beats_left <= beats_left - BURST_LEN'(1);
              end
            end
          end
        end
        DONE: begin
          if (read_req) begin
            rx_done <= 1'b1;
          end else begin
            state       <= IDLE;
            slave_ready <= 1'b1;
          end
        end
        default: begin
          state       <= IDLE;
          slave_ready <= 1'b1;
        end
      endcase
    end
  end

`ifndef SLAVE_IN_PARITY_EN
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_slave_in.sv
// Scoreboard bench for slave_in: driver pushes expected writes/reads/done pulses,
// a negedge monitor pops and compares whenever the DUT pulses an output.
module tb_slave_in;
  localparam int AL = 12;
  localparam int DL = 8;
  localparam int BL = 12;

  logic          clk;
  logic          reset;
  logic          slave_enable, master_valid, write_en, read_en;
  logic          rx_address, rx_burst, rx_data;
  logic          slave_ready, mem_we, read_req, rx_done, parity_err;
  logic [AL-1:0] mem_addr, read_addr;
  logic [DL-1:0] mem_wdata;
  logic [BL-1:0] read_burst;

  slave_in #(.ADDR_LEN(AL), .DATA_LEN(DL), .BURST_LEN(BL)) dut (
    .clk(clk), .reset(reset), .slave_enable(slave_enable), .master_valid(master_valid),
    .write_en(write_en), .read_en(read_en), .rx_address(rx_address), .rx_burst(rx_burst),
    .rx_data(rx_data), .slave_ready(slave_ready), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_we(mem_we), .read_req(read_req), .read_addr(read_addr), .read_burst(read_burst),
    .rx_done(rx_done), .parity_err(parity_err)
  );

  typedef struct { int addr; int data; int cyc; } exp_t;

  exp_t          wr_q[$];
  exp_t          rd_q[$];
  int            done_q[$];
  exp_t          mon_e;
  int            checks = 0;
  int            failures = 0;
  int            cyc = 0;
  int            bit_no = 0;
  int            forced_stall_bit = -1;
  int            stall_pct = 0;
  bit            exp_perr = 1'b0;
  logic [DL-1:0] beat_data [16];
  bit            bad_par [16];

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (reset) begin
      if (mem_we) begin
        if (wr_q.size() == 0) chk("unexpected_mem_we", 32'(mem_we), 0);
        else begin
          mon_e = wr_q.pop_front();
          chk("wr_addr", 32'(mem_addr), mon_e.addr);
          chk("wr_data", 32'(mem_wdata), mon_e.data);
          chk("wr_cycle", cyc, mon_e.cyc);
        end
      end
      if (read_req) begin
        if (rd_q.size() == 0) chk("unexpected_read_req", 32'(read_req), 0);
        else begin
          mon_e = rd_q.pop_front();
          chk("rd_addr", 32'(read_addr), mon_e.addr);
          chk("rd_burst", 32'(read_burst), mon_e.data);
          chk("rd_cycle", cyc, mon_e.cyc);
        end
      end
      if (rx_done) begin
        if (done_q.size() == 0) chk("unexpected_rx_done", 32'(rx_done), 0);
        else chk("done_cycle", cyc, done_q.pop_front());
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    master_valid = 1'b0; write_en = 1'b0; read_en = 1'b0; slave_enable = 1'b1;
    while (!slave_ready && n < 40) begin
      step();
      n++;
    end
    if (!slave_ready) chk("idle_timeout", 32'(slave_ready), 1);
  endtask

  task automatic drive_bit(input logic a, input logic b, input logic d, output int dc);
    int n;
    n = 0;
    if (bit_no == forced_stall_bit) n = 3;
    else if (stall_pct > 0 && int'($urandom_range(0, 99)) < stall_pct) n = int'($urandom_range(1, 3));
    repeat (n) begin
      master_valid = 1'b0;
      rx_address = 1'($urandom()); rx_burst = 1'($urandom()); rx_data = 1'($urandom());
      step();
    end
    master_valid = 1'b1; rx_address = a; rx_burst = b; rx_data = d;
    dc = cyc;
    step();
    bit_no++;
  endtask

  // abort_kind: 0 none, 1 drop slave_enable, 2 assert reset; applied before the given data bit
  task automatic run_txn(input bit we, input bit re, input logic [AL-1:0] addr,
                         input logic [BL-1:0] burst, input int abort_kind,
                         input int abort_beat, input int abort_bit);
    int dc, nb;
    logic [DL-1:0] d;
    logic par;
    bit ok;
    exp_t e;
    bit_no = 0;
    nb = (burst == '0) ? 1 : int'(burst);
    wait_idle();
    write_en = we; read_en = re;
    for (int i = 0; i < AL; i++) begin
      drive_bit(addr[i], (i < BL) ? burst[i] : 1'($urandom()), 1'($urandom()), dc);
      write_en = 1'b0; read_en = 1'b0;
    end
    if (!we) begin
      e.addr = int'(addr); e.data = nb; e.cyc = dc + 1;
      rd_q.push_back(e);
      done_q.push_back(dc + 2);
      return;
    end
    for (int k = 0; k < nb; k++) begin
      d = beat_data[k];
      for (int j = 0; j < DL; j++) begin
        if (abort_kind != 0 && k == abort_beat && j == abort_bit) begin
          if (abort_kind == 1) begin
            slave_enable = 1'b0; master_valid = 1'b1; rx_data = 1'($urandom());
            step();
            @(negedge clk);
            chk("abort_slave_ready", 32'(slave_ready), 1);
            step();
          end else begin
            reset = 1'b0;
            #1;
            chk("rst_slave_ready", 32'(slave_ready), 1);
            chk("rst_mem_we", 32'(mem_we), 0);
            chk("rst_rx_done", 32'(rx_done), 0);
            step(); step();
            reset = 1'b1;
            exp_perr = 1'b0;
          end
          return;
        end
        drive_bit(1'($urandom()), 1'($urandom()), d[j], dc);
      end
      ok = 1'b1;
`ifdef SLAVE_IN_PARITY_EN
      par = (^d) ^ bad_par[k];
      drive_bit(1'($urandom()), 1'($urandom()), par, dc);
      ok = !bad_par[k];
      if (!ok) exp_perr = 1'b1;
`else
      par = 1'b0;
`endif
      if (ok) begin
        e.addr = (int'(addr) + k) % (1 << AL); e.data = int'(d); e.cyc = dc + 1;
        wr_q.push_back(e);
      end
      if (k == nb - 1) done_q.push_back(dc + 1);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b0; slave_enable = 1'b0; master_valid = 1'b0; write_en = 1'b0; read_en = 1'b0;
    rx_address = 1'b0; rx_burst = 1'b0; rx_data = 1'b0;
    for (int i = 0; i < 16; i++) begin beat_data[i] = '0; bad_par[i] = 1'b0; end
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_slave_ready", 32'(slave_ready), 1);
    chk("reset_mem_we", 32'(mem_we), 0);
    chk("reset_read_req", 32'(read_req), 0);
    chk("reset_rx_done", 32'(rx_done), 0);
    chk("reset_parity_err", 32'(parity_err), 0);
    chk("reset_mem_addr", 32'(mem_addr), 0);
    step();
    reset = 1'b1;

    beat_data[0] = 8'hA5; beat_data[1] = 8'h3C; beat_data[2] = 8'hFF;
    run_txn(1'b1, 1'b0, 12'h010, 12'd3, 0, -1, -1);
    run_txn(1'b0, 1'b1, 12'h123, 12'd5, 0, -1, -1);
    beat_data[0] = 8'h11; beat_data[1] = 8'h22;
    run_txn(1'b1, 1'b0, 12'hFFF, 12'd2, 0, -1, -1);
    beat_data[0] = 8'h77;
    forced_stall_bit = AL + 4;
    run_txn(1'b1, 1'b0, 12'h2A0, 12'd0, 0, -1, -1);
    forced_stall_bit = -1;
    beat_data[0] = 8'hC3;
    run_txn(1'b1, 1'b1, 12'h055, 12'd1, 0, -1, -1);
    for (int i = 0; i < 4; i++) beat_data[i] = 8'(8'h40 + i);
    run_txn(1'b1, 1'b0, 12'h300, 12'd4, 1, 1, 3);
    run_txn(1'b1, 1'b0, 12'h400, 12'd2, 2, 0, 4);
`ifdef SLAVE_IN_PARITY_EN
    beat_data[0] = 8'h01; beat_data[1] = 8'h5A; bad_par[0] = 1'b1;
    run_txn(1'b1, 1'b0, 12'h500, 12'd2, 0, -1, -1);
    bad_par[0] = 1'b0;
    wait_idle();
    chk("parity_err_sticky", 32'(parity_err), 1);
`endif

    stall_pct = 15;
    repeat (40) begin
      int kind, nb, ab, abit, akind;
      logic [AL-1:0] a;
      logic [BL-1:0] bu;
      kind = int'($urandom_range(0, 9));
      a = ($urandom_range(0, 3) == 0) ? AL'(12'hFFE + $urandom_range(0, 1)) : AL'($urandom());
      if (kind < 3) begin
        bu = ($urandom_range(0, 4) == 0) ? '0 : BL'($urandom());
        run_txn(1'b0, 1'b1, a, bu, 0, -1, -1);
      end else begin
        bu = BL'($urandom_range(0, 5));
        nb = (bu == '0) ? 1 : int'(bu);
        for (int i = 0; i < 16; i++) begin
          beat_data[i] = DL'($urandom());
`ifdef SLAVE_IN_PARITY_EN
          bad_par[i] = ($urandom_range(0, 9) == 0);
`endif
        end
        akind = ($urandom_range(0, 9) == 0) ? 1 : 0;
        ab = int'($urandom_range(0, 15)) % nb;
        abit = int'($urandom_range(0, DL - 2));
        run_txn(1'b1, kind == 9, a, bu, akind, ab, abit);
      end
    end
    stall_pct = 0;
    wait_idle();
    repeat (5) step();

    chk("final_parity_err", 32'(parity_err), 32'(exp_perr));
    chk("pending_writes", wr_q.size(), 0);
    chk("pending_reads", rd_q.size(), 0);
    chk("pending_rx_done", done_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/slave_in.md
SLAVE_IN -- requirements
Module: slave_in

Interface
REQ-001 Parameter ADDR_LEN, 12, address width in bits; serial header length in cycles.
REQ-002 Parameter DATA_LEN, 8, data beat width in bits.
REQ-003 Parameter BURST_LEN, 12, burst count width; SHALL be <= ADDR_LEN.
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 slave_enable  input  1  decoded select for this slave; high for the whole transaction.
REQ-007 master_valid  input  1  serial lanes carry a valid bit this cycle.
REQ-008 write_en / read_en  input  1 each  transaction type, sampled at frame start.
REQ-009 rx_address / rx_burst / rx_data  input  1 each  serial lanes, LSB first.
REQ-010 slave_ready  output  1  high only in IDLE.
REQ-011 mem_addr  output  ADDR_LEN  write address; mem_wdata  output  DATA_LEN  write data.
REQ-012 mem_we  output  1  one-cycle write strobe.
REQ-013 read_req  output  1  one-cycle pulse; read_addr ADDR_LEN, read_burst BURST_LEN outputs valid with it.
REQ-014 rx_done  output  1  one-cycle end-of-transaction pulse; parity_err  output  1  sticky error flag.

Function
REQ-015 States IDLE, HEADER, DATA, DONE; one-hot or binary encoding is free.
REQ-016 Bits SHALL be sampled only in cycles with master_valid=1; master_valid=0 stalls the current phase and holds all counters.
REQ-017 IDLE -> HEADER when slave_enable=1, master_valid=1 and (write_en or read_en); the first header bit is sampled in that cycle; write_en=1 wins if both are high.
REQ-018 HEADER lasts ADDR_LEN sampled bits; rx_burst is shifted in during the first BURST_LEN of them.
REQ-019 Burst count 0 SHALL be treated as 1 beat.
REQ-020 Read, at end of HEADER: read_req=1 for one cycle with read_addr/read_burst, then DONE.
REQ-021 Write, at end of HEADER: go to DATA; each beat is DATA_LEN sampled rx_data bits.
REQ-022 Write beat: mem_we is registered, high in the cycle after the last bit of the beat, with mem_addr = base + beat index (mod 2^ADDR_LEN, wrap-around) and mem_wdata = beat.
REQ-023 Back-to-back beats: sampling of the next beat proceeds in the same cycle as mem_we of the previous beat, with no bubble.
REQ-024 After the final beat: DONE; rx_done=1 for one cycle concurrent with the final mem_we; then IDLE.
REQ-025 slave_enable=0 in HEADER or DATA: abort to IDLE next cycle; no further mem_we; no rx_done; a beat already completed still writes.
REQ-026 mem_we, read_req and rx_done are low in all cycles not stated above.

Reset
REQ-027 reset=0 SHALL immediately force IDLE and clear every register; outputs: slave_ready=1, all others 0.
REQ-028 Reset mid-transaction discards the partial beat; no mem_we is issued for it.

Configuration
REQ-029 Macro SLAVE_IN_PARITY_EN, when defined, appends one even-parity bit on rx_data after each beat (DATA_LEN+1 sampled bits per beat).
REQ-030 With SLAVE_IN_PARITY_EN defined: on parity mismatch, suppress that beat's mem_we, still advance the address, and set parity_err until reset.
REQ-031 Without SLAVE_IN_PARITY_EN: no parity bit is sampled, and parity_err is tied to 0.

Verification
REQ-032 Write addr 0x010, burst 3, data 0xA5,0x3C,0xFF, master_valid always high -> mem_we at 0x010/0x011/0x012 with those data, 8 cycles apart; rx_done with the last write.
REQ-033 Read addr 0x123, burst 5 -> read_req one cycle with read_addr=0x123 and read_burst=5, rx_done next cycle, no mem_we.
REQ-034 Write addr 0xFFF, burst 2, data 0x11,0x22 -> writes at 0xFFF then 0x000.
REQ-035 Burst 0, data 0x77 with master_valid low 3 cycles mid-beat -> single write of 0x77, delayed by exactly 3 cycles.
REQ-036 slave_enable dropped during beat 2 of burst 4 -> beat 1 written only; no rx_done; slave_ready=1 next cycle.
REQ-037 SLAVE_IN_PARITY_EN defined, beat 0x01 with parity bit 0 -> no mem_we for that beat, parity_err=1; next good beat writes to base+1.
